// File: rtl/round_pkg.sv
// round_pkg
// Shared definitions for the step rounding unit: rounding mode codes and the
// controller state encoding. Imported by round_step_seq and round_decide.
package round_pkg;

    // Rounding modes carried on the 2-bit mode input
    localparam logic [1:0] RND_NEAR  = 2'd0;  // nearest, ties round up
    localparam logic [1:0] RND_FLOOR = 2'd1;  // toward zero
    localparam logic [1:0] RND_CEIL  = 2'd2;  // away from zero
    localparam logic [1:0] RND_EVEN  = 2'd3;  // nearest, ties to even quotient

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/round_decide.sv
// round_decide
// Combinational rounding decision. Given the remainder and partial quotient
// left by the subtract loop, chooses whether to step up to the next multiple
// of STEP and flags results that no longer fit in WIDTH bits.
//
// Ports:
//   rem   in  WIDTH    remainder x mod STEP
//   base  in  WIDTH    largest multiple of STEP not above x
//   q_lsb in  1        LSB of the quotient x / STEP (for ties-to-even)
//   mode  in  2        rounding mode (round_pkg RND_*)
//   cand  out WIDTH+1  candidate result, one bit wider so it cannot wrap
//   ovf   out 1        cand exceeds 2^WIDTH-1
module round_decide
    import round_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 10
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] base,
    input  logic             q_lsb,
    input  logic [1:0]       mode,
    output logic [WIDTH:0]   cand,
    output logic             ovf
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_X  = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH:0] two_rem;
    logic           up;

    // Comparing 2*rem against STEP avoids a fractional half-step threshold;
    // the extra bit keeps 2*rem from wrapping for large remainders.
    always_comb begin
        two_rem = {rem, 1'b0};
        up      = 1'b0;
        case (mode)
            RND_NEAR:  up = (two_rem >= STEP_X);
            RND_FLOOR: up = 1'b0;
            RND_CEIL:  up = (rem != '0);
            RND_EVEN:  up = (two_rem > STEP_X) || ((two_rem == STEP_X) && q_lsb);
            default:   up = 1'b0;
        endcase
        cand = {1'b0, base} + (up ? STEP_X : '0);
        ovf  = (cand > MAX_X);
    end

endmodule

// File: rtl/round_step_seq.sv
// round_step_seq
// Sequential rounder: rounds an unsigned WIDTH-bit value to a multiple of STEP
// using a repeated-subtraction loop, then applies one of four rounding modes.
// Results above 2^WIDTH-1 saturate to the largest representable multiple.
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      request carries valid x/mode
//   in_ready   out 1      block can accept a request (IDLE and not in reset)
//   x          in  WIDTH  value to round, sampled at acceptance
//   mode       in  2      rounding mode (round_pkg RND_*)
//   out_valid  out 1      result available
//   out_ready  in  1      consumer takes the result
//   out        out WIDTH  rounded result, held while out_valid && !out_ready
//   ovf        out 1      result saturated, qualified by out_valid
//   busy       out 1      controller not in IDLE
module round_step_seq
    import round_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             busy
);

    // Reject parameter combinations the datapath cannot represent
    generate
        if (WIDTH < 4) begin : g_bad_width
            $error("round_step_seq: WIDTH must be at least 4");
        end
        if ((STEP < 2) || (longint'(STEP) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_step
            $error("round_step_seq: STEP must lie in 2 .. 2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_N   = {WIDTH{1'b1}};
    // Largest multiple of STEP that still fits in WIDTH bits
    localparam logic [WIDTH-1:0] SAT_MAX = MAX_N - (MAX_N % STEP_N);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] base;
    logic             q_lsb;
    logic [1:0]       mode_r;

    logic [WIDTH:0]   dec_cand;
    logic             dec_ovf;

    assign in_ready = (state == IDLE) && !rst;

    round_decide #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_decide (
        .rem   (rem),
        .base  (base),
        .q_lsb (q_lsb),
        .mode  (mode_r),
        .cand  (dec_cand),
        .ovf   (dec_ovf)
    );

    // Controller and subtract loop. base + rem always equals the captured x,
    // so base never overflows WIDTH bits while looping. q_lsb tracks the
    // quotient parity for ties-to-even without keeping a full quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem       <= '0;
            base      <= '0;
            q_lsb     <= 1'b0;
            mode_r    <= RND_NEAR;
            out       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem    <= x;
                        base   <= '0;
                        q_lsb  <= 1'b0;
                        mode_r <= mode;
                        busy   <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    if (rem >= STEP_N) begin
                        rem   <= rem - STEP_N;
                        base  <= base + STEP_N;
                        q_lsb <= ~q_lsb;
                    end else begin
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    // The carry bit of cand implies ovf; testing both keeps
                    // the selection robust to either flag alone.
                    if (dec_ovf || dec_cand[WIDTH]) begin
                        out <= SAT_MAX;
                        ovf <= 1'b1;
                    end else begin
                        out <= dec_cand[WIDTH-1:0];
                        ovf <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_step_seq.sv
// tb_round_step_seq
// Directed self-checking bench for round_step_seq. Instance A uses the default
// WIDTH=8/STEP=10; instance B uses WIDTH=12/STEP=100. Expected values are
// hand-computed from the rounding rules.
module tb_round_step_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
    logic [7:0]  a_x, a_out;
    logic [1:0]  a_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
    logic [11:0] b_x, b_out;
    logic [1:0]  b_mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    round_step_seq #(.WIDTH(8), .STEP(10)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .x         (a_x),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out       (a_out),
        .ovf       (a_ovf),
        .busy      (a_busy)
    );

    round_step_seq #(.WIDTH(12), .STEP(100)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .x         (b_x),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out       (b_out),
        .ovf       (b_ovf),
        .busy      (b_busy)
    );

    // Single comparison point: counts the check and reports any difference
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on instance sel and hold it until accepted. x is
    // scrambled afterwards so a late resample would corrupt the result.
    task automatic applyStimulus(input bit sel, input logic [11:0] xv, input logic [1:0] mv);
        bit accepted = 1'b0;
        bit rdy;
        int waited = 0;
        if (sel) begin
            b_x = xv; b_mode = mv; b_in_valid = 1'b1;
        end else begin
            a_x = xv[7:0]; a_mode = mv; a_in_valid = 1'b1;
        end
        while (!accepted && waited < 100) begin
            rdy = sel ? b_in_ready : a_in_ready;
            tick();
            waited++;
            if (rdy) accepted = 1'b1;
        end
        if (sel) begin
            b_in_valid = 1'b0; b_x = ~xv; b_mode = ~mv;
        end else begin
            a_in_valid = 1'b0; a_x = ~xv[7:0]; a_mode = ~mv;
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) for the result, check latency/out/ovf, then consume it
    task automatic checkOutput(input bit sel, input string tag, input logic [11:0] exp_out,
                               input logic exp_ovf, input int exp_lat);
        int lat = 0;
        logic ov;
        ov = sel ? b_out_valid : a_out_valid;
        while (!ov && lat < 300) begin
            tick();
            lat++;
            ov = sel ? b_out_valid : a_out_valid;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, sel ? {20'd0, b_out} : {24'd0, a_out}, {20'd0, exp_out});
        check({tag, "_ovf"}, sel ? b_ovf : a_ovf, exp_ovf);
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        a_out_ready = 1'b0;
        check({tag, "_consumed"}, sel ? b_out_valid : a_out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_x = '0; a_mode = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_x = '0; b_mode = '0; b_out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_out",      a_out,      8'd0);
        check("rst_ovf",      a_ovf,      1'b0);
        check("rst_valid",    a_out_valid, 1'b0);
        check("rst_busy",     a_busy,     1'b0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", a_in_ready, 1'b1);

        // Basic nearest rounding
        applyStimulus(0, 12'd26, 2'd0);  checkOutput(0, "x26_m0", 12'd30, 1'b0, 4);
        applyStimulus(0, 12'd53, 2'd0);  checkOutput(0, "x53_m0", 12'd50, 1'b0, 7);

        // Ties and directed modes
        applyStimulus(0, 12'd25, 2'd0);  checkOutput(0, "x25_m0", 12'd30, 1'b0, 4);
        applyStimulus(0, 12'd25, 2'd3);  checkOutput(0, "x25_m3", 12'd20, 1'b0, 4);
        applyStimulus(0, 12'd35, 2'd3);  checkOutput(0, "x35_m3", 12'd40, 1'b0, 5);
        applyStimulus(0, 12'd25, 2'd1);  checkOutput(0, "x25_m1", 12'd20, 1'b0, 4);
        applyStimulus(0, 12'd25, 2'd2);  checkOutput(0, "x25_m2", 12'd30, 1'b0, 4);

        // Saturation at the top of the range
        applyStimulus(0, 12'd255, 2'd0); checkOutput(0, "x255_m0", 12'd250, 1'b1, 27);
        applyStimulus(0, 12'd255, 2'd2); checkOutput(0, "x255_m2", 12'd250, 1'b1, 27);
        applyStimulus(0, 12'd255, 2'd1); checkOutput(0, "x255_m1", 12'd250, 1'b0, 27);

        // Zero and exact multiples in every mode
        for (int m = 0; m < 4; m++) begin
            applyStimulus(0, 12'd0, 2'(m));
            checkOutput(0, $sformatf("x0_m%0d", m), 12'd0, 1'b0, 2);
        end
        applyStimulus(0, 12'd40, 2'd2);  checkOutput(0, "x40_m2", 12'd40, 1'b0, 6);
        applyStimulus(0, 12'd40, 2'd0);  checkOutput(0, "x40_m0", 12'd40, 1'b0, 6);

        // Backpressure: hold the result while a new request waits
        applyStimulus(0, 12'd26, 2'd0);
        for (int i = 0; i < 4; i++) tick();
        check("bp_valid", a_out_valid, 1'b1);
        a_x = 8'd53; a_mode = 2'd1; a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out",      a_out,      8'd30);
            check("bp_ovf",      a_ovf,      1'b0);
            check("bp_in_ready", a_in_ready, 1'b0);
            check("bp_valid_hold", a_out_valid, 1'b1);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        check("bp_consumed",   a_out_valid, 1'b0);
        check("bp_idle_busy",  a_busy,      1'b0);
        check("bp_idle_ready", a_in_ready,  1'b1);
        tick();
        a_in_valid = 1'b0; a_x = 8'd0; a_mode = 2'd0;
        check("bp_accept_busy", a_busy, 1'b1);
        checkOutput(0, "bp_next", 12'd50, 1'b0, 7);

        // Reset in the middle of the subtract loop
        applyStimulus(0, 12'd200, 2'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", a_out_valid, 1'b0);
        check("midrst_out",   a_out,       8'd0);
        check("midrst_busy",  a_busy,      1'b0);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check("midrst_no_result", a_out_valid, 1'b0);
        applyStimulus(0, 12'd26, 2'd0);  checkOutput(0, "post_rst", 12'd30, 1'b0, 4);

        // Wider instance: WIDTH=12, STEP=100, SAT_MAX=4000
        applyStimulus(1, 12'd4095, 2'd1); checkOutput(1, "w12_4095_m1", 12'd4000, 1'b0, 42);
        applyStimulus(1, 12'd4095, 2'd2); checkOutput(1, "w12_4095_m2", 12'd4000, 1'b1, 42);
        applyStimulus(1, 12'd150, 2'd3);  checkOutput(1, "w12_150_m3",  12'd200,  1'b0, 3);
        applyStimulus(1, 12'd149, 2'd0);  checkOutput(1, "w12_149_m0",  12'd100,  1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
